// File: rtl/block_pkg.sv
// Purpose : shared screen geometry, cell size, colour constants and FSM encoding.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package block_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX_SIZE = 4;

  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a widened pixel coordinate lands inside the visible area.
  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py,
                                     input int w, input int h);
    return (int'(px) < w) && (int'(py) < h);
  endfunction

endpackage

// File: rtl/span_counter.sv
// Purpose : column/row offset counter walking one span row-major.
// Latency : offsets advance on the clock edge where en is high; next values are combinational.
// Backpressure: none; advances only when en is asserted, clear has priority over en.
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clear, en       zero both offsets / advance one pixel
//   col_limit       last column offset of the span (BOX_SIZE*cells-1)
//   col_nxt/row_nxt offsets the counter will hold after the next enabled edge
//   last            current offsets are the final pixel of the span
module span_counter
  import block_pkg::*;
#(
  parameter int BOX_SIZE = block_pkg::BOX_SIZE,
  parameter int COL_W    = 4,
  parameter int ROW_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [COL_W-1:0] col_limit,
  output logic [COL_W-1:0] col_nxt,
  output logic [ROW_W-1:0] row_nxt,
  output logic             last
);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_wrap;

  assign col_wrap = (col == col_limit);
  assign last     = col_wrap && (row == ROW_W'(BOX_SIZE - 1));

  always_comb begin
    col_nxt = col + COL_W'(1);
    row_nxt = row;
    if (col_wrap) begin
      col_nxt = '0;
      row_nxt = row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/draw_span.sv
// Purpose : draws a horizontal span of 1..MAX_CELLS square cells, one pixel per cycle.
// Latency : first pixel registered on the edge that samples start; done one cycle after last pixel.
// Backpressure: none; start is ignored while busy (no queuing).
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   start, x_in, y_in,            span request and its top-left corner, colour and
//   colour_in, cells_in           cell count (0 -> 1, >MAX_CELLS -> MAX_CELLS)
//   busy, done                    span in progress / one-cycle completion pulse
//   vga_x, vga_y, vga_colour, plot registered pixel stream to the VGA adapter
module draw_span
  import block_pkg::*;
#(
  parameter int BOX_SIZE  = block_pkg::BOX_SIZE,
  parameter int MAX_CELLS = 4,
  parameter int SCREEN_W  = block_pkg::SCREEN_W,
  parameter int SCREEN_H  = block_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] colour_in,
  input  logic [2:0] cells_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  localparam int COL_W = (BOX_SIZE * MAX_CELLS > 1) ? $clog2(BOX_SIZE * MAX_CELLS) : 1;
  localparam int ROW_W = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;

  state_t           state, state_nxt;
  logic [7:0]       x_q;
  logic [6:0]       y_q;
  logic [2:0]       colour_q;
  logic [2:0]       cells_q;
  logic [2:0]       cells_clamped;
  logic [COL_W-1:0] col_limit;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             last;
  logic             cnt_clear;
  logic             cnt_en;
  logic             pix_vld;
  logic [8:0]       px;
  logic [7:0]       py;
  logic [2:0]       pcolour;

  always_comb begin
    cells_clamped = cells_in;
    if (cells_in == 3'd0) begin
      cells_clamped = 3'd1;
    end else if (int'(cells_in) > MAX_CELLS) begin
      cells_clamped = 3'(MAX_CELLS);
    end
  end

  // cells_q is always 1..MAX_CELLS, so the limit never underflows.
  assign col_limit = COL_W'(int'(cells_q) * BOX_SIZE - 1);

  span_counter #(
    .BOX_SIZE (BOX_SIZE),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_span_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .en        (cnt_en),
    .col_limit (col_limit),
    .col_nxt   (col_nxt),
    .row_nxt   (row_nxt),
    .last      (last)
  );

  // The output registers always load the pixel the counter is about to hold,
  // so the (0,0) pixel is taken straight from the request inputs in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    pix_vld   = 1'b0;
    px        = {1'b0, x_q} + 9'(col_nxt);
    py        = {1'b0, y_q} + 8'(row_nxt);
    pcolour   = colour_q;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (start) begin
          state_nxt = DRAW;
          pix_vld   = 1'b1;
          px        = {1'b0, x_in};
          py        = {1'b0, y_in};
          pcolour   = colour_in;
        end
      end
      DRAW: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          cnt_en  = 1'b1;
          pix_vld = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_clear = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= BLACK;
      cells_q    <= 3'd1;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= BLACK;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        x_q      <= x_in;
        y_q      <= y_in;
        colour_q <= colour_in;
        cells_q  <= cells_clamped;
      end
      // Off-screen pixels still take their cycle but never assert plot.
      plot <= pix_vld && on_screen(px, py, SCREEN_W, SCREEN_H);
      if (pix_vld) begin
        vga_x      <= px[7:0];
        vga_y      <= py[6:0];
        vga_colour <= pcolour;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_draw_span.sv
module tb_draw_span;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic [2:0] cells_in;
  logic       busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  draw_span dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .colour_in  (colour_in),
    .cells_in   (cells_in),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  typedef struct {
    int x;
    int y;
    int col;
    int cells;
    int exp_plots;
    int exp_draws;
  } vec_t;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic int eff_cells(input int c);
    if (c == 0) return 1;
    if (c > 4) return 4;
    return c;
  endfunction

  // Number of visible pixels in a span, from the geometry alone.
  function automatic int model_plots(input int x, input int y, input int cells);
    int cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4 * eff_cells(cells); c++)
        if (x + c < 160 && y + r < 120) cnt++;
    return cnt;
  endfunction

  // Issues one span from a negedge with the DUT idle and observes N+3 cycles.
  // mode 1: extra start pulse in DRAW cycle 3; mode 2: extra start on the DONE cycle.
  task automatic run_span(input int x, input int y, input int col, input int cells,
                          input int mode, output int plots, output int draws,
                          output int done_at, output int mism);
    int w, n_pix, ex, ey;
    bit ep;
    w = 4 * eff_cells(cells);
    n_pix = 4 * w;
    plots = 0; draws = 0; done_at = -1; mism = 0;
    x_in = x[7:0]; y_in = y[6:0]; colour_in = col[2:0]; cells_in = cells[2:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x_in = 8'($urandom); y_in = 7'($urandom); colour_in = 3'($urandom); cells_in = 3'($urandom);
    for (int k = 1; k <= n_pix + 3; k++) begin
      if (plot) plots++;
      if (busy && !done) draws++;
      if (done && done_at < 0) done_at = k;
      if (k <= n_pix) begin
        ex = x + (k - 1) % w;
        ey = y + (k - 1) / w;
        ep = (ex < 160) && (ey < 120);
        if (busy !== 1'b1 || done !== 1'b0 || plot !== ep) mism++;
        else if (ep && (vga_x !== ex[7:0] || vga_y !== ey[6:0] || vga_colour !== col[2:0])) mism++;
      end else if (k == n_pix + 1) begin
        if (busy !== 1'b1 || done !== 1'b1 || plot !== 1'b0) mism++;
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) mism++;
      end
      start = (mode == 1 && k == 3) || (mode == 2 && k == n_pix + 1);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[5];
    int plots, draws, done_at, mism, x, y, c, n;
    int cnt_done, cnt_plot;

    vt[0] = '{8,   40,  4, 1, 16, 16};
    vt[1] = '{0,   116, 3, 3, 48, 48};
    vt[2] = '{156, 20,  5, 2, 16, 32};
    vt[3] = '{30,  10,  2, 0, 16, 16};
    vt[4] = '{50,  60,  7, 7, 64, 64};

    reset = 1'b0; start = 1'b1; x_in = 8'd77; y_in = 7'd33; colour_in = 3'd6; cells_in = 3'd2;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_span(vt[i].x, vt[i].y, vt[i].col, vt[i].cells, 0, plots, draws, done_at, mism);
      chk($sformatf("vec%0d_plots", i), plots, vt[i].exp_plots);
      chk($sformatf("vec%0d_draws", i), draws, vt[i].exp_draws);
      chk($sformatf("vec%0d_done_at", i), done_at, vt[i].exp_draws + 1);
      chk($sformatf("vec%0d_seq_mism", i), mism, 0);
    end

    for (int m = 1; m <= 2; m++) begin
      run_span(20, 30, 1, 2, m, plots, draws, done_at, mism);
      chk($sformatf("ign%0d_plots", m), plots, 32);
      chk($sformatf("ign%0d_draws", m), draws, 32);
      chk($sformatf("ign%0d_done_at", m), done_at, 33);
      chk($sformatf("ign%0d_seq_mism", m), mism, 0);
    end

    x_in = 8'd8; y_in = 7'd40; colour_in = 3'd4; cells_in = 3'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 1'b1;
    cnt_done = 0; cnt_plot = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (plot) cnt_plot++;
    end
    chk("abort_no_done", cnt_done, 0);
    chk("abort_no_plot", cnt_plot, 0);
    run_span(8, 40, 4, 1, 0, plots, draws, done_at, mism);
    chk("after_abort_plots", plots, 16);
    chk("after_abort_done_at", done_at, 17);
    chk("after_abort_seq_mism", mism, 0);

    for (int i = 0; i < 15; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 127));
      c = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 7));
      run_span(x, y, c, n, 0, plots, draws, done_at, mism);
      chk($sformatf("rnd%0d_plots", i), plots, model_plots(x, y, n));
      chk($sformatf("rnd%0d_draws", i), draws, 16 * eff_cells(n));
      chk($sformatf("rnd%0d_done_at", i), done_at, 16 * eff_cells(n) + 1);
      chk($sformatf("rnd%0d_seq_mism", i), mism, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/draw_span.md
DRAW_SPAN -- requirements
Module: draw_span

Interface
REQ-001 SHALL have parameter BOX_SIZE, 4, edge length in pixels of one block cell.
REQ-002 SHALL have parameter MAX_CELLS, 4, maximum cells drawn per request.
REQ-003 SHALL have parameter SCREEN_W, 160, visible width in pixels.
REQ-004 SHALL have parameter SCREEN_H, 120, visible height in pixels.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  request to draw one span, sampled only in IDLE.
REQ-008 SHALL have port x_in  input  8  top-left x of the span's first cell.
REQ-009 SHALL have port y_in  input  7  top-left y of the span.
REQ-010 SHALL have port colour_in  input  3  fill colour; 3'b000 erases.
REQ-011 SHALL have port cells_in  input  3  number of horizontally adjacent cells to draw.
REQ-012 SHALL have port busy  output  1  high in DRAW and DONE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a span completes.
REQ-014 SHALL have port vga_x  output  8  pixel x to VGA adapter.
REQ-015 SHALL have port vga_y  output  7  pixel y to VGA adapter.
REQ-016 SHALL have port vga_colour  output  3  pixel colour to VGA adapter.
REQ-017 SHALL have port plot  output  1  write-enable to VGA adapter for this cycle's pixel.

Function
REQ-018 SHALL implement FSM states IDLE, DRAW, DONE; IDLE->DRAW on start, DRAW->DONE after last pixel, DONE->IDLE unconditionally.
REQ-019 SHALL latch x_in, y_in, colour_in, cells_in on the edge where start is sampled in IDLE; later input changes do not affect the span.
REQ-020 SHALL clamp cells_in: 0 treated as 1, values above MAX_CELLS treated as MAX_CELLS.
REQ-021 SHALL emit exactly one pixel per cycle in DRAW, row-major: column offset 0..BOX_SIZE*cells-1 inner, row offset 0..BOX_SIZE-1 outer.
REQ-022 SHALL register all VGA outputs; first pixel (offset 0,0) appears on the cycle after start is sampled.
REQ-023 SHALL compute pixel x and y at 9 and 8 bits respectively; pixels with x>=SCREEN_W or y>=SCREEN_H SHALL drive plot low but still consume their cycle.
REQ-024 SHALL take exactly BOX_SIZE*BOX_SIZE*cells DRAW cycles; done SHALL be high for exactly one cycle, the cycle after the last pixel.
REQ-025 SHALL ignore start while busy is high, including the DONE cycle; no queuing.
REQ-026 SHALL hold plot low in IDLE and DONE; vga_x/vga_y/vga_colour hold their last values outside DRAW.

Reset
REQ-027 SHALL, when reset is low at a posedge, enter IDLE, clear counters, and drive busy=0, done=0, plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-028 SHALL abort a span in progress on reset with no further plot pulses and no done pulse.

Structure
REQ-029 SHALL take SCREEN_W, SCREEN_H, BOX_SIZE, colour constant BLACK=3'b000 and the FSM state encoding from shared package block_pkg.
REQ-030 SHALL place the column/row offset counters in one sub-module span_counter with enable, clear, column limit input and last-pixel output.

Verification
REQ-031 SHALL verify start with x=8,y=40,colour=3'b100,cells=1 -> 16 plot cycles, pixels (8..11,40..43) row-major, done on cycle 17, busy cycles 1..17.
REQ-032 SHALL verify cells=3 at x=0,y=116 -> 48 plot cycles covering x 0..11, y 116..119, then done.
REQ-033 SHALL verify x=156,cells=2 -> 32 DRAW cycles, plot high only for x 156..159 (16 pixels), done after cycle 32.
REQ-034 SHALL verify cells=0 -> 16 pixels drawn; cells=7 -> 64 pixels drawn.
REQ-035 SHALL verify start pulsed during DRAW and on the DONE cycle -> ignored, pixel count unchanged, IDLE afterwards.
REQ-036 SHALL verify reset low at DRAW cycle 5 -> plot=0 and busy=0 next cycle, no done; a new start then draws a full span.
